// File: rtl/qoi_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qoi_types (package)
// Purpose  : Shared types and defaults for the QOI host/engine buffer.
//            bank_state_t : per-bank ownership state (2-bit).
//            byte_t/addr_t: legacy port types for the DATA_W=8, DEPTH=256 build.
// Revision : 1.0 - N-bank ownership rotation
// ============================================================================
package qoi_types;

    localparam int unsigned c_DEFAULT_DATA_W = 8;
    localparam int unsigned c_DEFAULT_DEPTH  = 256;

    typedef logic [7:0] byte_t;
    typedef logic [7:0] addr_t;

    // HOST: host fills input RAM / drains output RAM.
    // QUEUED: handed over, waiting for the engine.
    // ENGINE: engine reads input RAM / fills output RAM.
    typedef enum logic [1:0] {
        BANK_HOST   = 2'd0,
        BANK_QUEUED = 2'd1,
        BANK_ENGINE = 2'd2
    } bank_state_t;

endpackage : qoi_types
`default_nettype wire

// File: rtl/qoi_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : qoi_bank_ram
// Purpose  : Single-port synchronous RAM, 1-cycle read latency. The read
//            register only updates on a read, so read data holds until the
//            next read of this RAM.
// Ports    : clk                  clock
//            i_en, i_we           enable / write enable
//            i_addr [ADDR_W]      word address
//            i_din  [DATA_W]      write data
//            o_dout [DATA_W]      registered read data
// Revision : 1.0 - initial
// ============================================================================
module qoi_bank_ram
    import qoi_types::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int DEPTH  = c_DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;

endmodule : qoi_bank_ram
`default_nettype wire

// File: rtl/qoi_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : qoi_pingpong_buffer
// Purpose  : N-bank host/engine buffer. Each bank has an input RAM (host
//            writes, engine reads) and an output RAM (engine writes, host
//            reads). Ownership rotates HOST -> QUEUED -> ENGINE -> HOST.
// Ports    : clk, rst (async, active-low)
//            a_*  host side : addr, data_i, data_o, cs, we, commit,
//                             avail, bank, err
//            b_*  engine    : addr, data_i, data_o, cs, we, acquire,
//                             release, ready, active, bank, err
//            err_clr        : clears a_err/b_err (a new error wins)
// Options  : QOI_AUTO_COMMIT_EN - a legal host write to DEPTH-1 also
//            commits the host bank in the same cycle.
// Revision : 1.0 - N-bank successor to the single-pair buffer
// ============================================================================
module qoi_pingpong_buffer
    import qoi_types::*;
#(
    parameter int DATA_W    = c_DEFAULT_DATA_W,
    parameter int DEPTH     = c_DEFAULT_DEPTH,
    parameter int NUM_BANKS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(DEPTH)-1:0]     a_addr,
    input  logic [DATA_W-1:0]            a_data_i,
    output logic [DATA_W-1:0]            a_data_o,
    input  logic                         a_cs,
    input  logic                         a_we,
    input  logic                         a_commit,
    output logic                         a_avail,
    output logic [$clog2(NUM_BANKS)-1:0] a_bank,
    input  logic [$clog2(DEPTH)-1:0]     b_addr,
    input  logic [DATA_W-1:0]            b_data_i,
    output logic [DATA_W-1:0]            b_data_o,
    input  logic                         b_cs,
    input  logic                         b_we,
    input  logic                         b_acquire,
    input  logic                         b_release,
    output logic                         b_ready,
    output logic                         b_active,
    output logic [$clog2(NUM_BANKS)-1:0] b_bank,
    input  logic                         err_clr,
    output logic                         a_err,
    output logic                         b_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BANK_W = $clog2(NUM_BANKS);

    bank_state_t       r_state     [NUM_BANKS];
    bank_state_t       w_state_nxt [NUM_BANKS];
    logic [BANK_W-1:0] r_hptr, r_eptr;
    logic              r_a_err, r_b_err;
    // Read-return bookkeeping: which bank answered and whether the read
    // was illegal (or reset) and must return zero.
    logic [BANK_W-1:0] r_a_rd_bank, r_b_rd_bank;
    logic              r_a_rd_zero, r_b_rd_zero;

    logic [DATA_W-1:0] w_in_dout  [NUM_BANKS];
    logic [DATA_W-1:0] w_out_dout [NUM_BANKS];

    logic w_a_avail, w_b_ready, w_b_active;
    logic w_auto_commit, w_commit_do, w_acquire_do, w_release_do;
    logic w_a_err_set, w_b_err_set;

    assign w_a_avail  = (r_state[r_hptr] == BANK_HOST);
    assign w_b_ready  = (r_state[r_eptr] == BANK_QUEUED);
    assign w_b_active = (r_state[r_eptr] == BANK_ENGINE);

`ifdef QOI_AUTO_COMMIT_EN
    assign w_auto_commit = w_a_avail & a_cs & a_we & (a_addr == ADDR_W'(DEPTH - 1));
`else
    assign w_auto_commit = 1'b0;
`endif

    // OR-ing the explicit and implicit commit makes a coincident pair count once.
    assign w_commit_do  = w_a_avail  & (a_commit | w_auto_commit);
    assign w_acquire_do = w_b_ready  & b_acquire;
    assign w_release_do = w_b_active & b_release;

    assign w_a_err_set = (a_commit  & ~w_a_avail) | (a_cs & ~w_a_avail);
    assign w_b_err_set = (b_release & ~w_b_active) | (b_cs & ~w_b_active);

    // A commit needs HOST, acquire needs QUEUED, release needs ENGINE, so
    // even when both pointers hit the same bank at most one update applies.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_state_nxt[i] = r_state[i];
        end
        if (w_commit_do)  w_state_nxt[r_hptr] = BANK_QUEUED;
        if (w_acquire_do) w_state_nxt[r_eptr] = BANK_ENGINE;
        if (w_release_do) w_state_nxt[r_eptr] = BANK_HOST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_state[i] <= BANK_HOST;
            end
            r_hptr      <= '0;
            r_eptr      <= '0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
            r_a_rd_bank <= '0;
            r_b_rd_bank <= '0;
            r_a_rd_zero <= 1'b1;
            r_b_rd_zero <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            if (w_commit_do)  r_hptr <= r_hptr + BANK_W'(1);
            if (w_release_do) r_eptr <= r_eptr + BANK_W'(1);

            if (w_a_err_set)  r_a_err <= 1'b1;
            else if (err_clr) r_a_err <= 1'b0;
            if (w_b_err_set)  r_b_err <= 1'b1;
            else if (err_clr) r_b_err <= 1'b0;

            if (a_cs & ~a_we) begin
                r_a_rd_bank <= r_hptr;
                r_a_rd_zero <= ~w_a_avail;
            end
            if (b_cs & ~b_we) begin
                r_b_rd_bank <= r_eptr;
                r_b_rd_zero <= ~w_b_active;
            end
        end
    end

    // The host-owned and engine-owned banks are always distinct, so each
    // RAM sees at most one legal accessor per cycle.
    generate
        for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
            logic w_own_a, w_own_b;
            logic w_in_en, w_in_we, w_out_en, w_out_we;

            assign w_own_a  = w_a_avail  & (r_hptr == BANK_W'(k));
            assign w_own_b  = w_b_active & (r_eptr == BANK_W'(k));
            assign w_in_we  = w_own_a & a_cs & a_we;
            assign w_in_en  = w_in_we | (w_own_b & b_cs & ~b_we);
            assign w_out_we = w_own_b & b_cs & b_we;
            assign w_out_en = w_out_we | (w_own_a & a_cs & ~a_we);

            qoi_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_in_ram (
                .clk    (clk),
                .i_en   (w_in_en),
                .i_we   (w_in_we),
                .i_addr (w_own_a ? a_addr : b_addr),
                .i_din  (a_data_i),
                .o_dout (w_in_dout[k])
            );

            qoi_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_out_ram (
                .clk    (clk),
                .i_en   (w_out_en),
                .i_we   (w_out_we),
                .i_addr (w_own_b ? b_addr : a_addr),
                .i_din  (b_data_i),
                .o_dout (w_out_dout[k])
            );
        end
    endgenerate

    assign a_data_o = r_a_rd_zero ? '0 : w_out_dout[r_a_rd_bank];
    assign b_data_o = r_b_rd_zero ? '0 : w_in_dout[r_b_rd_bank];
    assign a_avail  = w_a_avail;
    assign b_ready  = w_b_ready;
    assign b_active = w_b_active;
    assign a_bank   = r_hptr;
    assign b_bank   = r_eptr;
    assign a_err    = r_a_err;
    assign b_err    = r_b_err;

endmodule : qoi_pingpong_buffer
`default_nettype wire

// File: tb/tb_qoi_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qoi_pingpong_buffer
// Purpose  : Directed testbench for qoi_pingpong_buffer (2 banks, 8x256).
// Revision : 1.0 - initial
// ============================================================================
module tb_qoi_pingpong_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_addr, a_data_i, a_data_o;
    logic       a_cs, a_we, a_commit, a_avail;
    logic [0:0] a_bank;
    logic [7:0] b_addr, b_data_i, b_data_o;
    logic       b_cs, b_we, b_acquire, b_release, b_ready, b_active;
    logic [0:0] b_bank;
    logic       err_clr, a_err, b_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qoi_pingpong_buffer #(.DATA_W(8), .DEPTH(256), .NUM_BANKS(2)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_data_i(a_data_i), .a_data_o(a_data_o),
        .a_cs(a_cs), .a_we(a_we), .a_commit(a_commit),
        .a_avail(a_avail), .a_bank(a_bank),
        .b_addr(b_addr), .b_data_i(b_data_i), .b_data_o(b_data_o),
        .b_cs(b_cs), .b_we(b_we), .b_acquire(b_acquire), .b_release(b_release),
        .b_ready(b_ready), .b_active(b_active), .b_bank(b_bank),
        .err_clr(err_clr), .a_err(a_err), .b_err(b_err)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_cs = 0; a_we = 0; a_commit = 0; b_cs = 0; b_we = 0;
        b_acquire = 0; b_release = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle();
        a_addr = 0; a_data_i = 0; b_addr = 0; b_data_i = 0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        // host write then read of 0x10 without commit; read data is undefined
        a_cs = 1; a_we = 1; a_addr = 8'h10; a_data_i = 8'h5A; cyc();
        a_we = 0; cyc();
        idle(); a_commit = 1; cyc(); idle();
        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b0; #1;
        n_vec++; if (a_avail !== 1'b1) begin n_err++; $display("FAIL rst_a_avail got %b want 1", a_avail); end
        n_vec++; if (a_bank !== 1'b0) begin n_err++; $display("FAIL rst_a_bank got %0d want 0", a_bank); end
        n_vec++; if (a_data_o !== 8'h00) begin n_err++; $display("FAIL rst_a_data_o got %h want 00", a_data_o); end
        cyc(); rst = 1'b1; cyc();
        n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
        n_vec++; if (b_bank !== 1'b0) begin n_err++; $display("FAIL rst_b_bank got %0d want 0", b_bank); end
        n_vec++; if (b_data_o !== 8'h00) begin n_err++; $display("FAIL rst_b_data_o got %h want 00", b_data_o); end
        n_vec++; if ({a_err, b_err} !== 2'b00) begin n_err++; $display("FAIL rst_errs got %b want 00", {a_err, b_err}); end
    endtask

    task automatic test_roundtrip();
        a_cs = 1; a_we = 1; a_addr = 8'h10; a_data_i = 8'hA5; cyc();
        idle(); a_commit = 1; cyc(); idle();
        n_vec++; if (a_bank !== 1'b1) begin n_err++; $display("FAIL rt_a_bank got %0d want 1", a_bank); end
        n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL rt_b_ready got %b want 1", b_ready); end
        b_acquire = 1; cyc(); idle();
        n_vec++; if ({b_active, b_ready} !== 2'b10) begin n_err++; $display("FAIL rt_acquire got %b want 10", {b_active, b_ready}); end
        b_cs = 1; b_we = 0; b_addr = 8'h10; cyc(); idle();
        n_vec++; if (b_data_o !== 8'hA5) begin n_err++; $display("FAIL rt_b_read got %h want a5", b_data_o); end
        cyc();
        n_vec++; if (b_data_o !== 8'hA5) begin n_err++; $display("FAIL rt_b_hold got %h want a5", b_data_o); end
        b_cs = 1; b_we = 1; b_addr = 8'h10; b_data_i = 8'h3C; cyc();
        idle(); b_release = 1; cyc(); idle();
        n_vec++; if ({b_active, b_bank} !== 2'b01) begin n_err++; $display("FAIL rt_release got %b want 01", {b_active, b_bank}); end
        // wrap host pointer back to bank 0 by committing bank 1
        a_commit = 1; cyc(); idle();
        n_vec++; if ({a_avail, a_bank} !== 2'b10) begin n_err++; $display("FAIL rt_wrap got %b want 10", {a_avail, a_bank}); end
        a_cs = 1; a_we = 0; a_addr = 8'h10; cyc(); idle();
        n_vec++; if (a_data_o !== 8'h3C) begin n_err++; $display("FAIL rt_a_read got %h want 3c", a_data_o); end
        n_vec++; if ({a_err, b_err} !== 2'b00) begin n_err++; $display("FAIL rt_errs got %b want 00", {a_err, b_err}); end
        // drain bank 1 so both banks return to HOST
        b_acquire = 1; cyc(); idle(); b_release = 1; cyc(); idle();
        n_vec++; if ({a_avail, b_ready, b_active, a_bank, b_bank} !== 5'b10000) begin
            n_err++; $display("FAIL rt_drain got %b want 10000", {a_avail, b_ready, b_active, a_bank, b_bank});
        end
    endtask

    task automatic test_overflow();
        a_commit = 1; cyc(); cyc(); idle();
        n_vec++; if ({a_avail, a_bank} !== 2'b00) begin n_err++; $display("FAIL ov_full got %b want 00", {a_avail, a_bank}); end
        a_commit = 1; cyc(); idle();
        n_vec++; if ({a_err, a_bank} !== 2'b10) begin n_err++; $display("FAIL ov_commit_err got %b want 10", {a_err, a_bank}); end
        err_clr = 1; a_commit = 1; cyc(); idle();
        n_vec++; if (a_err !== 1'b1) begin n_err++; $display("FAIL ov_set_beats_clr got %b want 1", a_err); end
        err_clr = 1; cyc(); idle();
        n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL ov_clr got %b want 0", a_err); end
        a_cs = 1; a_we = 0; a_addr = 8'h10; cyc(); idle();
        n_vec++; if ({a_data_o, a_err} !== 9'h001) begin n_err++; $display("FAIL ov_illegal_read got %h want 001", {a_data_o, a_err}); end
        err_clr = 1; cyc(); idle();
    endtask

    task automatic test_engine_err();
        b_cs = 1; b_we = 0; b_addr = 8'h10; cyc(); idle();
        n_vec++; if ({b_data_o, b_err} !== 9'h001) begin n_err++; $display("FAIL eg_illegal_read got %h want 001", {b_data_o, b_err}); end
        err_clr = 1; cyc(); idle();
        n_vec++; if (b_err !== 1'b0) begin n_err++; $display("FAIL eg_clr got %b want 0", b_err); end
        b_release = 1; cyc(); idle();
        n_vec++; if ({b_err, b_bank} !== 2'b10) begin n_err++; $display("FAIL eg_bad_release got %b want 10", {b_err, b_bank}); end
        err_clr = 1; cyc(); idle();
        repeat (2) begin
            b_acquire = 1; cyc(); idle(); b_release = 1; cyc(); idle();
        end
        n_vec++; if ({a_avail, b_ready, a_bank, b_bank, b_err} !== 5'b10000) begin
            n_err++; $display("FAIL eg_drain got %b want 10000", {a_avail, b_ready, a_bank, b_bank, b_err});
        end
    endtask

    task automatic test_back_to_back();
        a_commit = 1; b_acquire = 1; cyc(); idle();
        n_vec++; if ({b_active, b_ready} !== 2'b01) begin n_err++; $display("FAIL bb_same_cycle got %b want 01", {b_active, b_ready}); end
        b_acquire = 1; cyc(); idle();
        n_vec++; if (b_active !== 1'b1) begin n_err++; $display("FAIL bb_second_acquire got %b want 1", b_active); end
        b_release = 1; cyc(); idle();
        n_vec++; if ({a_bank, b_bank, a_avail} !== 3'b111) begin n_err++; $display("FAIL bb_ptrs got %b want 111", {a_bank, b_bank, a_avail}); end
    endtask

    task automatic test_auto_commit();
        // host and engine both on bank 1, all banks HOST
        a_cs = 1; a_we = 1; a_addr = 8'hFF; a_data_i = 8'h77; cyc(); idle();
`ifdef QOI_AUTO_COMMIT_EN
        n_vec++; if ({a_bank, b_ready} !== 2'b01) begin n_err++; $display("FAIL ac_commit got %b want 01", {a_bank, b_ready}); end
        b_acquire = 1; cyc(); idle();
        b_cs = 1; b_we = 0; b_addr = 8'hFF; cyc(); idle();
        n_vec++; if (b_data_o !== 8'h77) begin n_err++; $display("FAIL ac_data got %h want 77", b_data_o); end
`else
        n_vec++; if ({a_bank, a_avail, b_ready} !== 3'b110) begin n_err++; $display("FAIL ac_no_commit got %b want 110", {a_bank, a_avail, b_ready}); end
`endif
        n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL ac_err got %b want 0", a_err); end
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_overflow();
        test_engine_err();
        test_back_to_back();
        test_auto_commit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_qoi_pingpong_buffer
`default_nettype wire

// File: doc/qoi_pingpong_buffer.md
Name: qoi_pingpong_buffer

Overview:
- Parametrised N-bank successor to the single-pair host/engine buffer. Each bank holds one input RAM and one output RAM.
- Bank ownership rotates automatically between the host side (port A, 6502 bus) and the QOI engine side (port B) through a per-bank state machine, so no external sel is needed.
- Lets the host fill bank k+1 and drain the results of bank k−1 while the engine works on bank k.

Parameters:
- DATA_W, 8, data width of both ports and all RAMs.
- DEPTH, 256, words per RAM; must be a power of 2. Localparam ADDR_W = $clog2(DEPTH).
- NUM_BANKS, 2, number of bank pairs; must be a power of 2 and ≥2. Localparam BANK_W = $clog2(NUM_BANKS).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- a_addr  in  ADDR_W  host word address
- a_data_i  in  DATA_W  host write data (goes to input RAM)
- a_data_o  out  DATA_W  host read data (comes from output RAM)
- a_cs, a_we  in  1  host chip select / write enable
- a_commit  in  1  pulse: hand the current host bank to the engine
- a_avail  out  1  current host bank is in state HOST
- a_bank  out  BANK_W  host bank pointer
- b_addr  in  ADDR_W  engine word address
- b_data_i  in  DATA_W  engine write data (goes to output RAM)
- b_data_o  out  DATA_W  engine read data (comes from input RAM)
- b_cs, b_we  in  1  engine chip select / write enable
- b_acquire  in  1  engine claims a queued bank (level or pulse)
- b_release  in  1  pulse: engine is finished with its bank
- b_ready  out  1  engine-pointer bank is QUEUED
- b_active  out  1  engine-pointer bank is ENGINE
- b_bank  out  BANK_W  engine pointer
- err_clr  in  1  clears a_err and b_err
- a_err, b_err  out  1  sticky protocol-violation flags

Behaviour:
- Per-bank state HOST → QUEUED → ENGINE → HOST; 2-bit encoding, enum in the package.
- Reset (rst low, asynchronous):
  - all banks HOST, hptr=eptr=0;
  - a_data_o=b_data_o=0, a_err=b_err=0;
  - RAM contents undefined.
- Host transitions:
  - a_commit while state[hptr]==HOST: state[hptr]←QUEUED, hptr←hptr+1 mod NUM_BANKS.
  - a_commit otherwise: ignored, a_err←1.
- Engine transitions:
  - b_acquire while state[eptr]==QUEUED: state[eptr]←ENGINE.
  - b_acquire otherwise: ignored, no error.
  - b_release while state[eptr]==ENGINE: state[eptr]←HOST, eptr←eptr+1.
  - b_release otherwise: ignored, b_err←1.
- Simultaneous events:
  - The two pointers address different banks, or the same bank in different states, so concurrent host and engine transitions never collide.
  - If a_commit and b_acquire target the same bank in the same cycle, acquire sees the pre-commit state (HOST) and is ignored; b_ready rises the next cycle.
- Accesses:
  - Host accesses are legal only when a_avail; engine accesses only when b_active.
  - Writes: a_cs&a_we writes a_data_i into input RAM[hptr][a_addr]. b_cs&b_we writes b_data_i into output RAM[eptr][b_addr].
  - Reads: a_cs&~a_we returns output RAM[hptr][a_addr] on a_data_o one cycle later. b_cs&~b_we returns input RAM[eptr][b_addr] on b_data_o one cycle later.
  - Read data holds until the next read.
- Illegal access (cs while the bank is not owned): write dropped, read data is 0, the side's err←1.
- An access in the same cycle as a commit or release uses the pre-transition bank and state.
- a_avail, b_ready, b_active and the pointers are registered state decoded combinationally; no extra latency.
- err_clr has lower priority than a new error set in the same cycle.
- Depth wrap: addresses are ADDR_W wide, so no out-of-range addresses exist.
- Reset mid-operation: all ownership returns to HOST and in-flight reads are discarded.

Optional Feature:
- Macro QOI_AUTO_COMMIT_EN.
- Defined:
  - A legal host write to address DEPTH−1 acts as an implicit a_commit in the same cycle; the write lands in the old bank.
  - An explicit a_commit in that same cycle counts as one commit, not two.
- Undefined: only a_commit commits; the last-address write is an ordinary write.

Decomposition:
- qoi_types package:
  - bank_state_t enum {BANK_HOST, BANK_QUEUED, BANK_ENGINE};
  - default DATA_W/DEPTH constants;
  - the existing byte_t/addr_t stay the port types when DATA_W=8 and DEPTH fits addr_t.
- Sub-module qoi_bank_ram: single-port synchronous RAM, parametrised DATA_W/DEPTH, separate din/dout, 1-cycle read, no tristates. Instantiated 2×NUM_BANKS times by a generate loop, with per-bank muxing of address and enables.

Test Plan:
- Reset with a host write then read of addr 0x10 (no commit): write is in the input RAM, so the read returns the output RAM contents (undefined). After reset: a_avail=1, b_ready=0, a_bank=0, b_bank=0, outputs 0, no errors.
- Host writes 0xA5 to 0x10, commits; engine acquires and reads 0x10 → b_data_o=0xA5 one cycle after b_cs. Engine writes 0x3C to 0x10, releases; host on bank 0 (after wrapping with NUM_BANKS=2) reads 0x3C.
- NUM_BANKS=2 full pipeline: commit bank0, commit bank1 → third a_commit while a_avail=0 sets a_err, hptr stays 0. err_clr clears it.
- Engine read while b_active=0 → b_data_o=0, b_err=1. b_release with no active bank → b_err=1, eptr unchanged.
- Same-cycle a_commit + b_acquire on bank0 → b_active=0 that cycle, b_ready=1 next cycle, second acquire succeeds.
- With QOI_AUTO_COMMIT_EN: write to 0xFF → bank0 QUEUED, hptr=1, data 0xFF word stored in bank0. Without the macro: bank0 stays HOST.
